// File: rtl/delay_arbiter_pkg.sv
// Shared constants and the round-robin pick helper for the delay arbiter.
package delay_arbiter_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DEPTH_DEF   = 3;
  localparam int WIDTH_DEF   = 8;
  localparam int RR_MAX      = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] index;
  } rr_pick_t;

  // Scans modulo RR_MAX; callers zero-pad unused request bits, which makes the
  // result identical to a modulo-NUM_REQ scan.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req, input logic [3:0] ptr);
    rr_pick_t   res;
    logic [3:0] idx;
    res = '0;
    for (int i = 0; i < RR_MAX; i++) begin
      idx = ptr + 4'(i);
      if (!res.found && req[idx]) begin
        res.found = 1'b1;
        res.index = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/delay_arbiter_pipe.sv
// Fixed-latency shift register of {valid, tag, data} with in-flight popcount.
module delay_arbiter_pipe
  import delay_arbiter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TAGW  = 2,
  parameter int WIDTH = WIDTH_DEF,
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [TAGW-1:0]  i_tag,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [TAGW-1:0]  o_tag,
  output logic [WIDTH-1:0] o_data,
  output logic [CNTW-1:0]  o_count
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [TAGW-1:0]  tag_q  [DEPTH];
  logic [TAGW-1:0]  tag_d  [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  always_comb begin
    valid_d   = '0;
    tag_d     = '{default: '0};
    data_d    = '{default: '0};
    valid_d[0] = i_valid;
    tag_d[0]   = i_tag;
    data_d[0]  = i_data;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      tag_d[i]   = tag_q[i-1];
      data_d[i]  = data_q[i-1];
    end
    if (i_flush) valid_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
      data_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    o_count = '0;
    for (int i = 0; i < DEPTH; i++) o_count = o_count + CNTW'(valid_q[i]);
  end

  assign o_valid = valid_q[DEPTH-1];
  assign o_tag   = tag_q[DEPTH-1];
  assign o_data  = data_q[DEPTH-1];

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin arbiter feeding one shared fixed-latency delay pipeline;
// each beat returns DEPTH cycles later tagged with its requester index.
module delay_arbiter
  import delay_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  localparam int TAGW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNTW   = $clog2(DEPTH + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*WIDTH-1:0] i_data,
  output logic [NUM_REQ-1:0]       o_gnt,
  output logic [NUM_REQ-1:0]       o_valid,
  output logic [WIDTH-1:0]         o_data,
  output logic [TAGW-1:0]          o_tag,
  output logic [CNTW-1:0]          o_inflight
);

  logic [TAGW-1:0]  ptr_q, ptr_d;
  rr_pick_t         pick;
  logic [TAGW-1:0]  gnt_idx;
  logic             accept;
  logic [WIDTH-1:0] acc_data;
  logic             last_valid;
  logic [TAGW-1:0]  last_tag;
  logic [WIDTH-1:0] last_data;

  always_comb begin
    pick     = rr_pick(RR_MAX'(i_req), 4'(ptr_q));
    gnt_idx  = TAGW'(pick.index);
    accept   = pick.found & ~i_flush & ~i_rst;
    o_gnt    = accept ? (NUM_REQ'(1) << gnt_idx) : '0;
    acc_data = i_data[gnt_idx*WIDTH +: WIDTH];
    ptr_d    = ptr_q;
    if (accept) ptr_d = (gnt_idx == TAGW'(NUM_REQ - 1)) ? '0 : gnt_idx + TAGW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  delay_arbiter_pipe #(
    .DEPTH (DEPTH),
    .TAGW  (TAGW),
    .WIDTH (WIDTH)
  ) u_pipe (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_valid (accept),
    .i_tag   (gnt_idx),
    .i_data  (acc_data),
    .o_valid (last_valid),
    .o_tag   (last_tag),
    .o_data  (last_data),
    .o_count (o_inflight)
  );

  // Tag and data are masked so idle cycles present clean zeros downstream.
  assign o_valid = last_valid ? (NUM_REQ'(1) << last_tag) : '0;
  assign o_tag   = last_valid ? last_tag  : '0;
  assign o_data  = last_valid ? last_data : '0;

endmodule

// File: tb/tb_delay_arbiter.sv
// Directed vector bench: NUM_REQ=4/DEPTH=3 table plus a NUM_REQ=1/DEPTH=1 ramp.
module tb_delay_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt, vld;
  logic [7:0]  odat;
  logic [1:0]  tag, infl;

  logic        rst1, flush1;
  logic [0:0]  req1;
  logic [7:0]  data1;
  logic [0:0]  gnt1, vld1;
  logic [7:0]  odat1;
  logic [0:0]  tag1, infl1;

  int total = 0;
  int bad   = 0;

  delay_arbiter #(.NUM_REQ(4), .DEPTH(3), .WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_req(req), .i_data(data),
    .o_gnt(gnt), .o_valid(vld), .o_data(odat), .o_tag(tag), .o_inflight(infl)
  );

  delay_arbiter #(.NUM_REQ(1), .DEPTH(1), .WIDTH(8)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_flush(flush1), .i_req(req1), .i_data(data1),
    .o_gnt(gnt1), .o_valid(vld1), .o_data(odat1), .o_tag(tag1), .o_inflight(infl1)
  );

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [3:0]  vld;
    logic [7:0]  odat;
    logic [1:0]  tag;
    logic [1:0]  infl;
  } vec_t;

  localparam int NV = 33;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, input logic f, input logic [3:0] q,
                              input logic [31:0] d, input logic [3:0] g, input logic [3:0] v,
                              input logic [7:0] od, input logic [1:0] t, input logic [1:0] n);
    vec_t x;
    x.rst = r; x.flush = f; x.req = q; x.data = d;
    x.gnt = g; x.vld = v; x.odat = od; x.tag = t; x.infl = n;
    return x;
  endfunction

  task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  localparam logic [31:0] D = 32'h44332211;

  initial begin
    // single beat from lane 2
    tbl[0]  = mk(0, 0, 4'b0100, 32'h00A50000, 4'b0100, 4'b0000, 8'h00, 2'd0, 2'd0);
    tbl[1]  = mk(0, 0, 4'b0000, 32'h0,        4'b0000, 4'b0000, 8'h00, 2'd0, 2'd1);
    tbl[2]  = mk(0, 0, 4'b0000, 32'h0,        4'b0000, 4'b0000, 8'h00, 2'd0, 2'd1);
    tbl[3]  = mk(0, 0, 4'b0000, 32'h0,        4'b0000, 4'b0100, 8'hA5, 2'd2, 2'd1);
    tbl[4]  = mk(0, 0, 4'b0000, 32'h0,        4'b0000, 4'b0000, 8'h00, 2'd0, 2'd0);
    // ptr=3, requests on 0 and 1: wrap and skip
    tbl[5]  = mk(0, 0, 4'b0011, 32'h44332211, 4'b0001, 4'b0000, 8'h00, 2'd0, 2'd0);
    tbl[6]  = mk(0, 0, 4'b0011, 32'h88776655, 4'b0010, 4'b0000, 8'h00, 2'd0, 2'd1);
    tbl[7]  = mk(0, 0, 4'b0011, 32'hCCBBAA99, 4'b0001, 4'b0000, 8'h00, 2'd0, 2'd2);
    tbl[8]  = mk(0, 0, 4'b0000, 32'h0,        4'b0000, 4'b0001, 8'h11, 2'd0, 2'd3);
    tbl[9]  = mk(0, 0, 4'b0000, 32'h0,        4'b0000, 4'b0010, 8'h66, 2'd1, 2'd2);
    tbl[10] = mk(0, 0, 4'b0000, 32'h0,        4'b0000, 4'b0001, 8'h99, 2'd0, 2'd1);
    tbl[11] = mk(0, 0, 4'b0000, 32'h0,        4'b0000, 4'b0000, 8'h00, 2'd0, 2'd0);
    // reset, then all four request for 8 cycles
    tbl[12] = mk(1, 0, 4'b1111, D, 4'b0000, 4'b0000, 8'h00, 2'd0, 2'd0);
    tbl[13] = mk(0, 0, 4'b1111, D, 4'b0001, 4'b0000, 8'h00, 2'd0, 2'd0);
    tbl[14] = mk(0, 0, 4'b1111, D, 4'b0010, 4'b0000, 8'h00, 2'd0, 2'd1);
    tbl[15] = mk(0, 0, 4'b1111, D, 4'b0100, 4'b0000, 8'h00, 2'd0, 2'd2);
    tbl[16] = mk(0, 0, 4'b1111, D, 4'b1000, 4'b0001, 8'h11, 2'd0, 2'd3);
    tbl[17] = mk(0, 0, 4'b1111, D, 4'b0001, 4'b0010, 8'h22, 2'd1, 2'd3);
    tbl[18] = mk(0, 0, 4'b1111, D, 4'b0010, 4'b0100, 8'h33, 2'd2, 2'd3);
    tbl[19] = mk(0, 0, 4'b1111, D, 4'b0100, 4'b1000, 8'h44, 2'd3, 2'd3);
    tbl[20] = mk(0, 0, 4'b1111, D, 4'b1000, 4'b0001, 8'h11, 2'd0, 2'd3);
    // flush with a beat exiting
    tbl[21] = mk(0, 1, 4'b0001, D, 4'b0000, 4'b0010, 8'h22, 2'd1, 2'd3);
    tbl[22] = mk(0, 0, 4'b0000, 32'h0, 4'b0000, 4'b0000, 8'h00, 2'd0, 2'd0);
    tbl[23] = mk(0, 0, 4'b0000, 32'h0, 4'b0000, 4'b0000, 8'h00, 2'd0, 2'd0);
    tbl[24] = mk(0, 0, 4'b0000, 32'h0, 4'b0000, 4'b0000, 8'h00, 2'd0, 2'd0);
    // two beats in flight, then reset drops them
    tbl[25] = mk(0, 0, 4'b0001, 32'h00000011, 4'b0001, 4'b0000, 8'h00, 2'd0, 2'd0);
    tbl[26] = mk(0, 0, 4'b0010, 32'h00002200, 4'b0010, 4'b0000, 8'h00, 2'd0, 2'd1);
    tbl[27] = mk(1, 0, 4'b1010, 32'h00002200, 4'b0000, 4'b0000, 8'h00, 2'd0, 2'd2);
    tbl[28] = mk(0, 0, 4'b1010, 32'h00005A00, 4'b0010, 4'b0000, 8'h00, 2'd0, 2'd0);
    tbl[29] = mk(0, 0, 4'b0000, 32'h0, 4'b0000, 4'b0000, 8'h00, 2'd0, 2'd1);
    tbl[30] = mk(0, 0, 4'b0000, 32'h0, 4'b0000, 4'b0000, 8'h00, 2'd0, 2'd1);
    tbl[31] = mk(0, 0, 4'b0000, 32'h0, 4'b0000, 4'b0010, 8'h5A, 2'd1, 2'd1);
    tbl[32] = mk(0, 0, 4'b0000, 32'h0, 4'b0000, 4'b0000, 8'h00, 2'd0, 2'd0);

    rst = 1'b1; flush = 1'b0; req = 4'b1111; data = '0;
    rst1 = 1'b1; flush1 = 1'b0; req1 = 1'b1; data1 = '0;
    #1;
    chk("gnt_in_reset", -1, 32'(gnt), 32'h0);
    chk("gnt1_in_reset", -1, 32'(gnt1), 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      rst = tbl[i].rst; flush = tbl[i].flush; req = tbl[i].req; data = tbl[i].data;
      #1;
      chk("gnt",      i, 32'(gnt),  32'(tbl[i].gnt));
      chk("valid",    i, 32'(vld),  32'(tbl[i].vld));
      chk("data",     i, 32'(odat), 32'(tbl[i].odat));
      chk("tag",      i, 32'(tag),  32'(tbl[i].tag));
      chk("inflight", i, 32'(infl), 32'(tbl[i].infl));
      @(posedge clk); #1;
    end

    // NUM_REQ=1, DEPTH=1: ramp delayed by one cycle
    rst = 1'b0; flush = 1'b0; req = '0; data = '0;
    rst1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      req1  = (k < 6) ? 1'b1 : 1'b0;
      data1 = 8'(k);
      #1;
      chk("n1_gnt",      k, 32'(gnt1),  32'(k < 6));
      chk("n1_valid",    k, 32'(vld1),  32'(k >= 1 && k <= 6));
      chk("n1_data",     k, 32'(odat1), (k >= 1 && k <= 6) ? 32'(k - 1) : 32'h0);
      chk("n1_tag",      k, 32'(tag1),  32'h0);
      chk("n1_inflight", k, 32'(infl1), 32'(k >= 1 && k <= 6));
      @(posedge clk); #1;
    end

    // NUM_REQ=1 flush suppresses the grant
    req1 = 1'b1; flush1 = 1'b1; data1 = 8'h77;
    #1;
    chk("n1_flush_gnt", 8, 32'(gnt1), 32'h0);
    @(posedge clk); #1;
    req1 = 1'b0; flush1 = 1'b0;
    #1;
    chk("n1_flush_valid", 9, 32'(vld1), 32'h0);
    chk("n1_flush_inflight", 9, 32'(infl1), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
